// File: rtl/fetch_pkg.sv
// Shared types and sizing for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned FETCH_BUF_DEPTH = 2;
    localparam int unsigned ROM_LATENCY     = 1;
    localparam int unsigned OCC_W           = $clog2(FETCH_BUF_DEPTH + 1);
    localparam int unsigned PTR_W           = $clog2(FETCH_BUF_DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: ROM address/data, core redirect and the (pc, instr) output stream.
interface instruction_fetch_if;

    logic [31:0] rom_addr;
    logic [31:0] rom_rd;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    modport master (
        output rom_addr, out_valid, out_pc, out_instr,
        input  rom_rd, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  rom_addr, out_valid, out_pc, out_instr,
        output rom_rd, redirect_valid, redirect_pc, out_ready
    );

endinterface

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of fetched (pc, instr) pairs; flush overrides push and pop.
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     wr_data,
    output fetch_entry_t     rd_data,
    output logic [OCC_W-1:0] occupancy
);

    fetch_entry_t     mem [FETCH_BUF_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop  = pop && (occupancy != '0);
        do_push = push && ((occupancy != OCC_W'(FETCH_BUF_DEPTH)) || do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            occupancy <= occupancy + OCC_W'(do_push) - OCC_W'(do_pop);
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, tracks the in-flight ROM read and buffers returned words.
// Optional statistics counters are enabled with INSTRUCTION_FETCH_STATS_EN.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0
)(
    input  logic                clk,
    input  logic                rst,
    instruction_fetch_if.master bus
`ifdef INSTRUCTION_FETCH_STATS_EN
    ,
    output logic [31:0]         stat_fetched,
    output logic [31:0]         stat_squashed
`endif
);

    logic [31:0]      pc;
    logic [31:0]      infl_pc;
    logic             inflight;
    logic [OCC_W-1:0] occ;
    logic [OCC_W:0]   pending;
    logic [OCC_W:0]   limit;
    fetch_entry_t     head;
    fetch_entry_t     ret;
    fetch_entry_t     sel;
    logic             out_valid;
    logic             pop;
    logic             issue;
    logic             push;
    logic             buf_pop;

    always_comb begin
        ret       = '{pc: infl_pc, instr: bus.rom_rd};
        out_valid = !rst && !bus.redirect_valid && ((occ != '0) || inflight);
        pop       = out_valid && bus.out_ready;
        // Issue only while buffered + in-flight words, net of this cycle's pop, leave room.
        pending   = {1'b0, occ} + (OCC_W + 1)'(inflight);
        limit     = (OCC_W + 1)'(FETCH_BUF_DEPTH) + (OCC_W + 1)'(pop);
        issue     = !bus.redirect_valid && (pending < limit);
        // A returning word skips the buffer only when the buffer is empty and it is taken now.
        push      = inflight && !bus.redirect_valid && !((occ == '0) && pop);
        buf_pop   = pop && (occ != '0);
        sel       = '0;
        if (out_valid) begin
            sel = (occ != '0) ? head : ret;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            infl_pc  <= '0;
            inflight <= 1'b0;
        end else if (bus.redirect_valid) begin
            pc       <= align_pc(bus.redirect_pc);
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                infl_pc <= pc;
                pc      <= pc + 32'd4;
            end
        end
    end

    fetch_buffer u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (buf_pop),
        .flush     (bus.redirect_valid),
        .wr_data   (ret),
        .rd_data   (head),
        .occupancy (occ)
    );

    assign bus.rom_addr  = {2'b00, pc[31:2]};
    assign bus.out_valid = out_valid;
    assign bus.out_pc    = sel.pc;
    assign bus.out_instr = sel.instr;

`ifdef INSTRUCTION_FETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_fetched  <= '0;
            stat_squashed <= '0;
        end else begin
            if (pop) begin
                stat_fetched <= stat_fetched + 32'd1;
            end
            if (bus.redirect_valid) begin
                stat_squashed <= stat_squashed + 32'(occ) + 32'(inflight);
            end
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed scoreboard bench for instruction_fetch; statistics checks follow INSTRUCTION_FETCH_STATS_EN.
module tb_instruction_fetch;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = -1000;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t sb[$];
    exp_t mon_e;

    instruction_fetch_if bus ();

`ifdef INSTRUCTION_FETCH_STATS_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_squashed;
`endif

    instruction_fetch #(.RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef INSTRUCTION_FETCH_STATS_EN
        ,
        .stat_fetched  (stat_fetched),
        .stat_squashed (stat_squashed)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a + 32'd1) * 32'h11;
    endfunction

    // Registered-output ROM: data follows the address by one cycle.
    always @(posedge clk) bus.rom_rd <= rom_word(bus.rom_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_out(input logic [31:0] pc, input logic [31:0] instr, input int c);
        exp_t e;
        e.pc = pc;
        e.instr = instr;
        e.cyc = c;
        sb.push_back(e);
    endtask

    // Monitor: every accepted word must be the next scoreboard entry, in the expected cycle.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out: got pc 0x%08h, expected no output (cycle %0d)", bus.out_pc, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("out_pc", bus.out_pc, mon_e.pc);
                check("out_instr", bus.out_instr, mon_e.instr);
                check("accept_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    initial begin
        bus.out_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_pc", bus.out_pc, 32'd0);
        check("rst_out_instr", bus.out_instr, 32'd0);
        check("rst_rom_addr", bus.rom_addr, 32'd0);

        @(posedge clk); #1;
        rst = 1'b0;
        cyc = 0;
        expect_out(32'h0, 32'h11, 1);
        expect_out(32'h4, 32'h22, 2);
        expect_out(32'h8, 32'h33, 3);
        expect_out(32'hC, 32'h44, 9);
        expect_out(32'h10, 32'h55, 10);
        expect_out(32'h14, 32'h66, 11);
        expect_out(32'h18, 32'h77, 12);
        expect_out(32'h40, 32'h121, 16);
        expect_out(32'hFFFF_FFFC, 32'h4000_0000, 19);
        expect_out(32'h0, 32'h11, 20);

        for (int c = 0; c < 23; c++) begin
            bus.out_ready = !((c >= 4 && c <= 8) || c == 13 || c == 14 || c == 21 || c == 22);
            bus.redirect_valid = (c == 14 || c == 17);
            bus.redirect_pc = (c == 14) ? 32'h43 : 32'hFFFF_FFFC;
            @(negedge clk);
            case (c)
                0: begin
                    check("c0_valid", 32'(bus.out_valid), 32'd0);
                    check("c0_rom_addr", bus.rom_addr, 32'd0);
                end
                5, 6, 7, 8: begin
                    check("stall_rom_addr", bus.rom_addr, 32'd5);
                    check("stall_valid", 32'(bus.out_valid), 32'd1);
                    check("stall_out_pc", bus.out_pc, 32'hC);
                    check("stall_out_instr", bus.out_instr, 32'h44);
                end
                14: check("redirect_valid_low", 32'(bus.out_valid), 32'd0);
                15: begin
                    check("post_redirect_valid", 32'(bus.out_valid), 32'd0);
                    check("redirect_target_addr", bus.rom_addr, 32'h10);
`ifdef INSTRUCTION_FETCH_STATS_EN
                    check("squashed_after_flush", stat_squashed, 32'd2);
`endif
                end
                17: check("redirect_ready_valid", 32'(bus.out_valid), 32'd0);
                18: begin
                    check("wrap_target_addr", bus.rom_addr, 32'h3FFF_FFFF);
`ifdef INSTRUCTION_FETCH_STATS_EN
                    check("squashed_after_drop", stat_squashed, 32'd3);
                    check("fetched_count", stat_fetched, 32'd8);
`endif
                end
                19: check("wrap_rom_addr", bus.rom_addr, 32'd0);
                default: ;
            endcase
            @(posedge clk); #1;
            cyc++;
        end

        // Reset with two words buffered.
        rst = 1'b1;
        bus.out_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
`ifdef INSTRUCTION_FETCH_STATS_EN
        check("fetched_before_rst", stat_fetched, 32'd10);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        cyc = 0;
        expect_out(32'h0, 32'h11, 1);
        expect_out(32'h4, 32'h22, 2);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 0) begin
                check("restart_valid", 32'(bus.out_valid), 32'd0);
                check("restart_out_pc", bus.out_pc, 32'd0);
                check("restart_rom_addr", bus.rom_addr, 32'd0);
`ifdef INSTRUCTION_FETCH_STATS_EN
                check("restart_fetched", stat_fetched, 32'd0);
                check("restart_squashed", stat_squashed, 32'd0);
`endif
            end
            @(posedge clk); #1;
            cyc++;
        end

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
